// File: rtl/load_store_unit_if.sv
// Data bus between the load/store unit (master) and data memory (slave):
// req/gnt address phase followed by an rvalid response phase.
interface load_store_unit_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  data_req_o;
  logic                  data_gnt_i;
  logic                  data_rvalid_i;
  logic [31:0]           data_rdata_i;
  logic [ADDR_WIDTH-1:0] data_addr_o;
  logic                  data_we_o;
  logic [3:0]            data_be_o;
  logic [31:0]           data_wdata_o;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// BURV data-memory access stage: one req/gnt/rvalid bus transaction per load/store.
// Optional misaligned-access trap: define LSU_MISALIGN_CHECK_EN.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lsu_en_i,
  input  logic                  irq_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_type_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  output logic                  lsu_err_o,
  output logic                  lsu_done_o,
  output logic [31:0]           lsu_rdata_o,
  load_store_unit_if.master     bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RVALID, DONE} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            type_q, off_q;
  logic                  sign_q, we_q;
  logic [3:0]            be_q, be_d;
  logic [31:0]           wdata_q, wdata_d, rdata_q, load_ext;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic                  start, capture_load;

`ifdef LSU_MISALIGN_CHECK_EN
  assign lsu_err_o = lsu_en_i & (((lsu_type_i == 2'b01) & lsu_addr_i[0]) |
                                 (lsu_type_i[1] & (lsu_addr_i[1:0] != 2'b00)));
`else
  // Misaligned accesses simply run with the low offset bits truncated.
  assign lsu_err_o = 1'b0;
`endif

  assign start = (state_q == IDLE) & lsu_en_i & ~irq_i & ~lsu_err_o;

  // Store lane steering from the live request, captured on accept.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = lsu_wdata_i;
    case (lsu_type_i)
      2'b00: begin
        be_d    = 4'b0001 << lsu_addr_i[1:0];
        wdata_d = {4{lsu_wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << {lsu_addr_i[1], 1'b0};
        wdata_d = {2{lsu_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_sel = bus.data_rdata_i[7:0];
    case (off_q)
      2'd1:    byte_sel = bus.data_rdata_i[15:8];
      2'd2:    byte_sel = bus.data_rdata_i[23:16];
      2'd3:    byte_sel = bus.data_rdata_i[31:24];
      default: ;
    endcase
    half_sel = off_q[1] ? bus.data_rdata_i[31:16] : bus.data_rdata_i[15:0];
    case (type_q)
      2'b00:   load_ext = {{24{sign_q & byte_sel[7]}}, byte_sel};
      2'b01:   load_ext = {{16{sign_q & half_sel[15]}}, half_sel};
      default: load_ext = bus.data_rdata_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    capture_load = 1'b0;
    case (state_q)
      IDLE:        if (start) state_d = REQ;
      REQ:         if (bus.data_gnt_i) state_d = WAIT_RVALID;
      WAIT_RVALID: if (bus.data_rvalid_i) begin
        state_d      = DONE;
        capture_load = ~we_q;
      end
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      type_q  <= '0;
      sign_q  <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        addr_q  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
        off_q   <= lsu_addr_i[1:0];
        type_q  <= lsu_type_i;
        sign_q  <= lsu_sign_ext_i;
        we_q    <= lsu_we_i;
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
      if (capture_load) rdata_q <= load_ext;
    end
  end

  // req decodes straight from state so reset drops it asynchronously.
  assign bus.data_req_o   = (state_q == REQ);
  assign bus.data_addr_o  = addr_q;
  assign bus.data_we_o    = we_q;
  assign bus.data_be_o    = be_q;
  assign bus.data_wdata_o = wdata_q;
  assign lsu_done_o       = (state_q == DONE);
  assign lsu_rdata_o      = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: expected bus/result values are queued at
// stimulus time and popped when the transaction completes.
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        lsu_en = 0, irq = 0, lsu_we = 0, lsu_sign = 0;
  logic [1:0]  lsu_type = 0;
  logic [31:0] lsu_addr = 0, lsu_wdata = 0;
  logic        lsu_err, lsu_done;
  logic [31:0] lsu_rdata;
  int          n_cmp = 0, n_err = 0;
  logic [31:0] last_rd = 0;

  load_store_unit_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .lsu_en_i(lsu_en), .irq_i(irq), .lsu_we_i(lsu_we),
    .lsu_type_i(lsu_type), .lsu_sign_ext_i(lsu_sign), .lsu_addr_i(lsu_addr),
    .lsu_wdata_i(lsu_wdata), .lsu_err_o(lsu_err), .lsu_done_o(lsu_done),
    .lsu_rdata_o(lsu_rdata), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic we; logic [1:0] typ; logic sgn;
    logic [31:0] addr, wdata, rdat;
    int gw, rw;
  } stim_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata; logic [3:0] be; logic we;
    int lat, req_n;
  } exp_t;

  typedef struct {
    logic [31:0] addr, wdata, rdata; logic [3:0] be; logic we, err, unstable, timeout;
    int lat, req_n;
  } obs_t;

  exp_t sb[$];

  function automatic exp_t model(input stim_t s, input logic [31:0] prev);
    exp_t e;
    logic [7:0] b [4];
    logic [7:0] v;
    logic [15:0] h;
    int off;
    for (int i = 0; i < 4; i++) b[i] = s.rdat[8*i +: 8];
    off = int'(s.addr[1:0]);
    e.addr  = s.addr & 32'hFFFF_FFFC;
    e.we    = s.we;
    e.lat   = 3 + s.gw + s.rw;
    e.req_n = s.gw + 1;
    if (s.typ == 2'b00) begin
      e.be = 4'b0; e.be[off] = 1'b1;
      e.wdata = {s.wdata[7:0], s.wdata[7:0], s.wdata[7:0], s.wdata[7:0]};
      v = b[off];
      e.rdata = (s.sgn && v[7]) ? {24'hFFFFFF, v} : {24'h0, v};
    end else if (s.typ == 2'b01) begin
      e.be = s.addr[1] ? 4'b1100 : 4'b0011;
      e.wdata = {s.wdata[15:0], s.wdata[15:0]};
      h = s.addr[1] ? {b[3], b[2]} : {b[1], b[0]};
      e.rdata = (s.sgn && h[15]) ? {16'hFFFF, h} : {16'h0, h};
    end else begin
      e.be = 4'b1111; e.wdata = s.wdata; e.rdata = s.rdat;
    end
    if (s.we) e.rdata = prev;
    return e;
  endfunction

  // Drives one request and plays the memory side; perturb scrambles controller
  // inputs and fires stray rvalids while the transaction is in flight.
  task automatic do_txn(input stim_t s, input bit perturb, output obs_t o);
    int cyc = 0, req_n = 0, wait_n = 0;
    bit done = 0;
    o = '{default: '0};
    @(posedge clk); #1;
    lsu_en = 1; irq = 0; lsu_we = s.we; lsu_type = s.typ; lsu_sign = s.sgn;
    lsu_addr = s.addr; lsu_wdata = s.wdata;
    bus.data_gnt_i = 0; bus.data_rvalid_i = 0;
    #1 o.err = lsu_err;
    while (!done && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_rdata_i = 32'hA5A5_A5A5;
      if (perturb) begin
        lsu_en = cyc[0]; irq = cyc[1]; lsu_we = ~s.we;
        lsu_addr = $urandom; lsu_wdata = $urandom; lsu_type = 2'($urandom);
      end
      #1;
      if (lsu_done) begin
        done = 1; o.lat = cyc; o.rdata = lsu_rdata; lsu_en = 0; irq = 0;
      end else if (bus.data_req_o) begin
        req_n++;
        if (req_n == 1) begin
          o.addr = bus.data_addr_o; o.be = bus.data_be_o;
          o.wdata = bus.data_wdata_o; o.we = bus.data_we_o;
        end else if (bus.data_addr_o !== o.addr || bus.data_be_o !== o.be ||
                     bus.data_wdata_o !== o.wdata || bus.data_we_o !== o.we)
          o.unstable = 1;
        if (req_n == s.gw + 1) bus.data_gnt_i = 1;
        else if (perturb) begin bus.data_rvalid_i = 1; bus.data_rdata_i = 32'h5A5A_5A5A; end
      end else begin
        wait_n++;
        if (wait_n == s.rw + 1) begin bus.data_rvalid_i = 1; bus.data_rdata_i = s.rdat; end
      end
    end
    o.req_n = req_n;
    o.timeout = !done;
    if (!done) lsu_en = 0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (bus.data_req_o !== 1'b0 || lsu_done !== 1'b0 || bus.data_we_o !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: got req=%b done=%b we=%b want 0/0/0", bus.data_req_o, lsu_done, bus.data_we_o); end
    n_cmp++; if (bus.data_be_o !== 4'h0 || bus.data_addr_o !== 32'h0 || bus.data_wdata_o !== 32'h0) begin
      n_err++; $display("FAIL reset_bus: got be=%h addr=%h wdata=%h want zeros", bus.data_be_o, bus.data_addr_o, bus.data_wdata_o); end
    n_cmp++; if (lsu_rdata !== 32'h0) begin
      n_err++; $display("FAIL reset_rdata: got %h want 0", lsu_rdata); end
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_loads();
    stim_t t[$];
    obs_t o; exp_t e;
    t.push_back('{0, 2'b10, 0, 32'h100, 0, 32'hDEADBEEF, 0, 0});
    t.push_back('{0, 2'b00, 1, 32'h103, 0, 32'h80FFFFFF, 0, 0});
    t.push_back('{0, 2'b00, 0, 32'h103, 0, 32'h80FFFFFF, 0, 0});
    t.push_back('{0, 2'b01, 1, 32'h202, 0, 32'h8001_7F00, 1, 0});
    t.push_back('{0, 2'b01, 0, 32'h200, 0, 32'h1234_F00D, 0, 1});
    t.push_back('{0, 2'b11, 0, 32'h300, 0, 32'h0BAD_CAFE, 0, 0});
    foreach (t[i]) begin
      sb.push_back(model(t[i], last_rd));
      do_txn(t[i], 0, o);
      e = sb.pop_front();
      last_rd = e.rdata;
      n_cmp++; if (o.timeout || o.lat != e.lat) begin
        n_err++; $display("FAIL load_latency[%0d]: got %0d (timeout=%b) want %0d", i, o.lat, o.timeout, e.lat); end
      n_cmp++; if (o.rdata !== e.rdata) begin
        n_err++; $display("FAIL load_rdata[%0d]: got %h want %h", i, o.rdata, e.rdata); end
      n_cmp++; if (o.addr !== e.addr || o.be !== e.be || o.we !== 1'b0 || o.err !== 1'b0) begin
        n_err++; $display("FAIL load_bus[%0d]: got addr=%h be=%b we=%b err=%b want addr=%h be=%b we=0 err=0", i, o.addr, o.be, o.we, o.err, e.addr, e.be); end
    end
  endtask

  task automatic test_stores();
    stim_t t[$];
    obs_t o; exp_t e;
    t.push_back('{1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'hFFFF_FFFF, 0, 0});
    t.push_back('{1, 2'b00, 0, 32'h101, 32'h0000_0077, 32'h0, 0, 1});
    t.push_back('{1, 2'b10, 0, 32'h104, 32'hCAFE_F00D, 32'h0, 1, 0});
    foreach (t[i]) begin
      sb.push_back(model(t[i], last_rd));
      do_txn(t[i], 0, o);
      e = sb.pop_front();
      n_cmp++; if (o.addr !== e.addr || o.be !== e.be || o.we !== 1'b1) begin
        n_err++; $display("FAIL store_addr_be[%0d]: got addr=%h be=%b we=%b want addr=%h be=%b we=1", i, o.addr, o.be, o.we, e.addr, e.be); end
      n_cmp++; if (o.wdata !== e.wdata) begin
        n_err++; $display("FAIL store_wdata[%0d]: got %h want %h", i, o.wdata, e.wdata); end
      n_cmp++; if (o.timeout || o.lat != e.lat || o.rdata !== e.rdata) begin
        n_err++; $display("FAIL store_done[%0d]: got lat=%0d rdata=%h want lat=%0d rdata=%h", i, o.lat, o.rdata, e.lat, e.rdata); end
    end
  endtask

  task automatic test_stall();
    stim_t s;
    obs_t o; exp_t e;
    s = '{0, 2'b10, 0, 32'h440, 0, 32'h7654_3210, 3, 1};
    sb.push_back(model(s, last_rd));
    do_txn(s, 1, o);
    e = sb.pop_front();
    last_rd = e.rdata;
    n_cmp++; if (o.req_n != e.req_n || o.unstable) begin
      n_err++; $display("FAIL stall_req: got %0d cycles unstable=%b want %0d stable", o.req_n, o.unstable, e.req_n); end
    n_cmp++; if (o.timeout || o.lat != 7) begin
      n_err++; $display("FAIL stall_latency: got %0d want 7", o.lat); end
    n_cmp++; if (o.addr !== e.addr || o.rdata !== e.rdata) begin
      n_err++; $display("FAIL stall_data: got addr=%h rdata=%h want addr=%h rdata=%h", o.addr, o.rdata, e.addr, e.rdata); end
    @(posedge clk); #2;
    n_cmp++; if (lsu_done !== 1'b0 || lsu_rdata !== e.rdata || bus.data_req_o !== 1'b0) begin
      n_err++; $display("FAIL done_pulse: got done=%b rdata=%h req=%b want 0/%h/0", lsu_done, lsu_rdata, bus.data_req_o, e.rdata); end
  endtask

  task automatic test_misalign();
    stim_t s;
    obs_t o; exp_t e;
    bit saw_req = 0;
`ifdef LSU_MISALIGN_CHECK_EN
    @(posedge clk); #1;
    lsu_en = 1; lsu_we = 0; lsu_type = 2'b10; lsu_addr = 32'h101;
    #1;
    n_cmp++; if (lsu_err !== 1'b1) begin
      n_err++; $display("FAIL misalign_err: got %b want 1", lsu_err); end
    repeat (5) begin @(posedge clk); #2; if (bus.data_req_o) saw_req = 1; end
    n_cmp++; if (saw_req) begin
      n_err++; $display("FAIL misalign_noreq: got req=1 want no request"); end
    lsu_en = 0;
`else
    s = '{0, 2'b10, 0, 32'h101, 0, 32'h1357_9BDF, 0, 0};
    sb.push_back(model(s, last_rd));
    do_txn(s, 0, o);
    e = sb.pop_front();
    last_rd = e.rdata;
    n_cmp++; if (o.err !== 1'b0 || o.addr !== 32'h100 || o.be !== 4'b1111) begin
      n_err++; $display("FAIL misalign_run: got err=%b addr=%h be=%b want 0/00000100/1111", o.err, o.addr, o.be); end
    n_cmp++; if (o.timeout || o.rdata !== e.rdata) begin
      n_err++; $display("FAIL misalign_rdata: got %h want %h", o.rdata, e.rdata); end
    saw_req = o.unstable;
    n_cmp++; if (saw_req) begin
      n_err++; $display("FAIL misalign_stable: got unstable bus want stable"); end
`endif
  endtask

  task automatic test_irq();
    bit saw = 0;
    @(posedge clk); #1;
    lsu_en = 1; irq = 1; lsu_we = 0; lsu_type = 2'b10; lsu_addr = 32'h200;
    repeat (5) begin @(posedge clk); #2; if (bus.data_req_o || lsu_done) saw = 1; end
    n_cmp++; if (saw) begin
      n_err++; $display("FAIL irq_block: got bus activity want none"); end
    lsu_en = 0; irq = 0;
  endtask

  task automatic test_reset_mid();
    bit saw = 0;
    @(posedge clk); #1;
    lsu_en = 1; lsu_we = 1; lsu_type = 2'b10; lsu_addr = 32'h600; lsu_wdata = 32'h1111_2222;
    bus.data_gnt_i = 0;
    @(posedge clk); #2;
    n_cmp++; if (bus.data_req_o !== 1'b1) begin
      n_err++; $display("FAIL midreset_pre: got req=%b want 1", bus.data_req_o); end
    rst = 1; lsu_en = 0;
    #1;
    n_cmp++; if (bus.data_req_o !== 1'b0 || bus.data_be_o !== 4'h0 || lsu_rdata !== 32'h0) begin
      n_err++; $display("FAIL midreset_async: got req=%b be=%b rdata=%h want 0/0000/0", bus.data_req_o, bus.data_be_o, lsu_rdata); end
    last_rd = 0;
    @(posedge clk); #1 rst = 0;
    repeat (3) begin @(posedge clk); #2; if (bus.data_req_o || lsu_done) saw = 1; end
    n_cmp++; if (saw) begin
      n_err++; $display("FAIL midreset_idle: got activity after reset want idle"); end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    obs_t o; exp_t e;
    for (int i = 0; i < 10; i++) begin
      s.we = 1'($urandom); s.typ = 2'($urandom); s.sgn = 1'($urandom);
      s.addr = 32'h1000 + ($urandom_range(0, 255) << 2);
      if (s.typ == 2'b00) s.addr[1:0] = 2'($urandom);
      else if (s.typ == 2'b01) s.addr[1] = 1'($urandom);
      s.wdata = $urandom; s.rdat = $urandom;
      s.gw = $urandom_range(0, 2); s.rw = $urandom_range(0, 2);
      sb.push_back(model(s, last_rd));
      do_txn(s, i[0], o);
      e = sb.pop_front();
      last_rd = e.rdata;
      n_cmp++; if (o.timeout || o.lat != e.lat || o.req_n != e.req_n || o.unstable) begin
        n_err++; $display("FAIL b2b_timing[%0d]: got lat=%0d req=%0d want lat=%0d req=%0d", i, o.lat, o.req_n, e.lat, e.req_n); end
      n_cmp++; if (o.addr !== e.addr || o.be !== e.be || o.we !== e.we) begin
        n_err++; $display("FAIL b2b_bus[%0d]: got %h/%b/%b want %h/%b/%b", i, o.addr, o.be, o.we, e.addr, e.be, e.we); end
      n_cmp++; if ((e.we && o.wdata !== e.wdata) || o.rdata !== e.rdata) begin
        n_err++; $display("FAIL b2b_data[%0d]: got wdata=%h rdata=%h want wdata=%h rdata=%h", i, o.wdata, o.rdata, e.wdata, e.rdata); end
    end
  endtask

  initial begin
    bus.data_gnt_i = 0; bus.data_rvalid_i = 0; bus.data_rdata_i = 0;
    test_reset();
    test_loads();
    test_stores();
    test_stall();
    test_misalign();
    test_irq();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
